axis_spi_slave: RTL and testbench

- SPI slave (peripheral) endpoint, the far end of the link driven by axis_spi_master; used as a loopback target in system benches and as an FPGA-side SPI peripheral.
- Oversamples external SCLK/CS/MOSI on clk_i and deserialises MOSI words onto an AXI-Stream master output.
- Serialises words taken from an AXI-Stream slave input onto MISO.
- Supports all four SPI modes, MSB first.

---
 rtl/axis_spi_pkg.sv | 25 ++
 rtl/spi_sync_edge.sv | 35 +++
 rtl/axis_spi_slave.sv | 178 +++++++++++++++++
 tb/tb_axis_spi_slave.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_spi_pkg.sv
// Shared SPI definitions for the AXI-Stream SPI master/slave pair.
package axis_spi_pkg;

    typedef enum logic [1:0] {
        SPI_MODE_0 = 2'd0,
        SPI_MODE_1 = 2'd1,
        SPI_MODE_2 = 2'd2,
        SPI_MODE_3 = 2'd3
    } spi_mode_t;

    localparam int unsigned SYNC_STAGES = 2;

    function automatic logic cpol(spi_mode_t mode);
        logic [1:0] m;
        m = mode;
        return m[1];
    endfunction

    function automatic logic cpha(spi_mode_t mode);
        logic [1:0] m;
        m = mode;
        return m[0];
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-stage synchroniser for an asynchronous input with registered
// single-cycle rise/fall pulses.
module spi_sync_edge
    import axis_spi_pkg::*;
#(
    parameter int unsigned STAGES = SYNC_STAGES
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Chain and history stay out of reset so a level held through reset
    // produces no edge afterwards; only the pulses are cleared.
    always_ff @(posedge clk_i) begin
        sync_q <= {sync_q[STAGES-2:0], d_i};
        prev_q <= sync_q[STAGES-1];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rise_o <= 1'b0;
            fall_o <= 1'b0;
        end else begin
            rise_o <= sync_q[STAGES-1] & ~prev_q;
            fall_o <= ~sync_q[STAGES-1] & prev_q;
        end
    end

endmodule

// File: rtl/axis_spi_slave.sv
// SPI slave endpoint: oversampled SCLK/CS/MOSI, MOSI words to an AXIS master
// port, MISO words from an AXIS slave port through a one-entry holding register.
module axis_spi_slave
    import axis_spi_pkg::*;
#(
    parameter int unsigned               SPI_MODE   = 0,
    parameter int unsigned               DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]     DUMMY_WORD = '0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  spi_clk_i,
    input  logic                  spi_cs_i,
    input  logic                  spi_mosi_i,
    output logic                  spi_miso_o,
    output logic                  spi_miso_oe_o,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  underrun_o,
    output logic                  overrun_o
);

    localparam spi_mode_t   MODE  = spi_mode_t'(SPI_MODE[1:0]);
    localparam logic        CPOL  = cpol(MODE);
    localparam logic        CPHA  = cpha(MODE);
    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    logic sclk_rise, sclk_fall, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic mosi_s;

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sclk_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spi_clk_i),
        .rise_o (sclk_rise),
        .fall_o (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES)) u_cs_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (spi_cs_i),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    always_ff @(posedge clk_i) begin
        mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi_i};
    end
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    logic lead_edge, trail_edge, sample_edge, shift_edge;
    assign lead_edge   = CPOL ? sclk_fall : sclk_rise;
    assign trail_edge  = CPOL ? sclk_rise : sclk_fall;
    assign sample_edge = CPHA ? trail_edge : lead_edge;
    assign shift_edge  = CPHA ? lead_edge  : trail_edge;

    state_t                state_q, state_d;
    logic                  start_frame, end_frame, sample_en, shift_en;
    logic [CNT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] rx_shift_q, tx_shift_q, hold_data_q, m_tdata_q;
    logic                  hold_valid_q, ready_en_q, miso_q;
    logic                  m_tvalid_q, underrun_q, overrun_q;
    logic                  word_done, tx_load, tx_hs;
    logic [DATA_WIDTH-1:0] load_word, rx_word;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        sample_en   = 1'b0;
        shift_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d     = ST_ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d   = ST_IDLE;
                    end_frame = 1'b1;
                end else begin
                    sample_en = sample_edge;
                    shift_en  = shift_edge;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign word_done = sample_en && (bit_cnt_q == LAST_BIT);
    assign tx_load   = start_frame || word_done;
    assign tx_hs     = s_axis_tvalid && s_axis_tready;
    assign load_word = hold_valid_q ? hold_data_q : DUMMY_WORD;
    assign rx_word   = {rx_shift_q[DATA_WIDTH-2:0], mosi_s};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_en_q   <= 1'b0;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            tx_shift_q   <= '0;
            miso_q       <= 1'b0;
            rx_shift_q   <= '0;
            bit_cnt_q    <= '0;
            m_tdata_q    <= '0;
            m_tvalid_q   <= 1'b0;
            underrun_q   <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            ready_en_q <= 1'b1;
            underrun_q <= tx_load && !hold_valid_q;
            overrun_q  <= word_done && m_tvalid_q && !m_axis_tready;

            // A load consumes the current entry; a same-cycle handshake refills it.
            if (tx_load)    hold_valid_q <= tx_hs;
            else if (tx_hs) hold_valid_q <= 1'b1;
            if (tx_hs)      hold_data_q  <= s_axis_tdata;

            if (end_frame) begin
                miso_q     <= 1'b0;
                tx_shift_q <= '0;
            end else if (tx_load) begin
                if (start_frame && !CPHA) begin
                    miso_q     <= load_word[DATA_WIDTH-1];
                    tx_shift_q <= load_word << 1;
                end else begin
                    tx_shift_q <= load_word;
                end
            end else if (shift_en) begin
                miso_q     <= tx_shift_q[DATA_WIDTH-1];
                tx_shift_q <= tx_shift_q << 1;
            end

            if (end_frame) begin
                bit_cnt_q  <= '0;
                rx_shift_q <= '0;
            end else if (sample_en) begin
                rx_shift_q <= rx_word;
                bit_cnt_q  <= word_done ? '0 : bit_cnt_q + 1'b1;
            end

            if (word_done && (!m_tvalid_q || m_axis_tready)) begin
                m_tdata_q  <= rx_word;
                m_tvalid_q <= 1'b1;
            end else if (m_axis_tready) begin
                m_tvalid_q <= 1'b0;
            end
        end
    end

    assign spi_miso_o    = miso_q;
    assign spi_miso_oe_o = (state_q == ST_ACTIVE);
    assign s_axis_tready = ready_en_q && !hold_valid_q;
    assign m_axis_tdata  = m_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign underrun_o    = underrun_q;
    assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_axis_spi_slave.sv
// Scoreboard bench: one slave instance per SPI mode, driven by a behavioural
// SPI master at clk/8; RX words are checked by a monitor against a queue.
module tb_axis_spi_slave;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] sclk = 4'b1100;
    logic [3:0] cs = 4'hF;
    logic       mosi = 1'b0;
    logic [7:0] s_tdata = '0;
    logic [3:0] s_tvalid = '0;
    logic [3:0] m_tready = 4'hF;
    logic [3:0] miso, oe, s_tready, m_tvalid, underrun, overrun;
    logic [7:0] m_tdata [4];

    int   checks = 0;
    int   failures = 0;
    int   under_cnt [4] = '{0, 0, 0, 0};
    int   over_cnt  [4] = '{0, 0, 0, 0};
    exp_t exp_q [$];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        axis_spi_slave #(
            .SPI_MODE   (g),
            .DATA_WIDTH (8),
            .DUMMY_WORD (8'hFF)
        ) u_dut (
            .clk_i         (clk),
            .rst_i         (rst),
            .spi_clk_i     (sclk[g]),
            .spi_cs_i      (cs[g]),
            .spi_mosi_i    (mosi),
            .spi_miso_o    (miso[g]),
            .spi_miso_oe_o (oe[g]),
            .s_axis_tdata  (s_tdata),
            .s_axis_tvalid (s_tvalid[g]),
            .s_axis_tready (s_tready[g]),
            .m_axis_tdata  (m_tdata[g]),
            .m_axis_tvalid (m_tvalid[g]),
            .m_axis_tready (m_tready[g]),
            .underrun_o    (underrun[g]),
            .overrun_o     (overrun[g])
        );
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (underrun[i]) under_cnt[i]++;
                if (overrun[i])  over_cnt[i]++;
                if (m_tvalid[i] && m_tready[i]) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL rx_unexpected: inst %0d got %02h, required no word", i, m_tdata[i]);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        if (e.idx != i || e.data !== m_tdata[i]) begin
                            failures++;
                            $display("FAIL rx_word: inst %0d got %02h, required inst %0d %02h",
                                     i, m_tdata[i], e.idx, e.data);
                        end
                    end
                end
            end
        end
    end

    task automatic expect_rx(input int i, input logic [7:0] d);
        exp_t e;
        e.idx  = i;
        e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic push_tx(input int i, input logic [7:0] d);
        int n;
        n = 0;
        s_tdata     = d;
        s_tvalid[i] = 1'b1;
        @(negedge clk);
        while (!s_tready[i] && n < 400) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        s_tvalid[i] = 1'b0;
        chk("tx_accept_in_time", 32'(n < 400), 1);
    endtask

    task automatic cs_low(input int i, input logic [7:0] first);
        mosi  = first[7];
        cs[i] = 1'b0;
        cyc(8);
    endtask

    task automatic cs_high(input int i);
        cyc(4);
        cs[i] = 1'b1;
        cyc(8);
    endtask

    // Master side of one word: returns the MISO bits it sampled, MSB first.
    task automatic spi_word(input int i, input logic [7:0] tx, input int nbits,
                            input bit lat, output logic [7:0] rxb);
        logic [1:0] md;
        logic       pol, pha;
        md  = 2'(i);
        pol = md[1];
        pha = md[0];
        rxb = '0;
        for (int b = 0; b < nbits; b++) begin
            if (!pha) begin
                mosi       = tx[7-b];
                rxb[7-b]   = miso[i];
            end
            sclk[i] = !pol;
            if (pha) mosi = tx[7-b];
            if (lat && !pha && b == nbits - 1) begin
                cyc(3);
                chk("latency_3_cycles_not_yet", 32'(m_tvalid[i]), 0);
                cyc(1);
                chk("latency_4_cycles_valid", 32'(m_tvalid[i]), 1);
            end else begin
                cyc(4);
            end
            if (pha) rxb[7-b] = miso[i];
            sclk[i] = pol;
            cyc(4);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] b1, b2;
        int u0, o0, n;

        // Reset values
        cyc(5);
        chk("rst_s_tready", 32'(s_tready), 0);
        chk("rst_oe", 32'(oe), 0);
        chk("rst_miso", 32'(miso), 0);
        chk("rst_m_tvalid", 32'(m_tvalid), 0);
        rst = 1'b0;
        cyc(1);
        chk("post_rst_s_tready", 32'(s_tready), 32'hF);
        chk("post_rst_m_tdata0", 32'(m_tdata[0]), 0);
        chk("post_rst_pulses", 32'({underrun, overrun}), 0);

        // Mode 0: TX 0x3C preloaded, RX 0xA5 with latency check
        push_tx(0, 8'h3C);
        cs_low(0, 8'hA5);
        chk("mode0_oe_active", 32'(oe[0]), 1);
        expect_rx(0, 8'hA5);
        spi_word(0, 8'hA5, 8, 1'b1, b1);
        cs_high(0);
        chk("mode0_miso_3c", 32'(b1), 32'h3C);
        chk("mode0_oe_idle", 32'(oe[0]), 0);

        // Modes 1..3: back-to-back words in one frame
        for (int m = 1; m < 4; m++) begin
            u0 = under_cnt[m];
            push_tx(m, 8'h55);
            cs_low(m, 8'h81);
            expect_rx(m, 8'h81);
            expect_rx(m, 8'h7E);
            fork
                begin
                    spi_word(m, 8'h81, 8, 1'b0, b1);
                    spi_word(m, 8'h7E, 8, 1'b0, b2);
                end
                begin
                    push_tx(m, 8'hAA);
                    push_tx(m, 8'h00);
                end
            join
            cs_high(m);
            chk($sformatf("mode%0d_miso_w0", m), 32'(b1), 32'h55);
            chk($sformatf("mode%0d_miso_w1", m), 32'(b2), 32'hAA);
            chk($sformatf("mode%0d_no_underrun", m), 32'(under_cnt[m] - u0), 0);
        end

        // No TX data: DUMMY_WORD and underrun at CS fall
        u0 = under_cnt[0];
        cs_low(0, 8'h12);
        chk("dummy_underrun_at_cs_fall", 32'(under_cnt[0] - u0), 1);
        expect_rx(0, 8'h12);
        spi_word(0, 8'h12, 8, 1'b0, b1);
        cs_high(0);
        chk("dummy_miso_ff", 32'(b1), 32'hFF);

        // Overrun: tready held low over two words
        m_tready[0] = 1'b0;
        o0 = over_cnt[0];
        expect_rx(0, 8'h11);
        cs_low(0, 8'h11);
        spi_word(0, 8'h11, 8, 1'b0, b1);
        cs_high(0);
        cs_low(0, 8'h22);
        spi_word(0, 8'h22, 8, 1'b0, b1);
        cs_high(0);
        chk("overrun_pulses_once", 32'(over_cnt[0] - o0), 1);
        chk("overrun_tvalid_held", 32'(m_tvalid[0]), 1);
        chk("overrun_old_word_kept", 32'(m_tdata[0]), 32'h11);
        m_tready[0] = 1'b1;
        cyc(4);
        chk("overrun_drained", 32'(m_tvalid[0]), 0);

        // Aborted partial frame, then a full one
        push_tx(0, 8'hC3);
        cs_low(0, 8'hF0);
        spi_word(0, 8'hF0, 5, 1'b0, b1);
        cs_high(0);
        chk("partial_miso_bits", 32'(b1 & 8'hF8), 32'hC0);
        chk("partial_no_tvalid", 32'(m_tvalid[0]), 0);
        push_tx(0, 8'h5A);
        cs_low(0, 8'h0F);
        expect_rx(0, 8'h0F);
        spi_word(0, 8'h0F, 8, 1'b0, b1);
        cs_high(0);
        chk("after_partial_miso_5a", 32'(b1), 32'h5A);

        // Reset pulse during the 4th bit
        cs_low(0, 8'h66);
        spi_word(0, 8'h66, 3, 1'b0, b1);
        mosi    = 1'b0;
        sclk[0] = 1'b1;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("midrst_oe", 32'(oe[0]), 0);
        chk("midrst_miso", 32'(miso[0]), 0);
        chk("midrst_s_tready", 32'(s_tready[0]), 0);
        chk("midrst_m_tvalid", 32'(m_tvalid[0]), 0);
        chk("midrst_pulses", 32'({underrun[0], overrun[0]}), 0);
        cyc(1);
        chk("midrst_s_tready_after", 32'(s_tready[0]), 1);
        cyc(1);
        sclk[0] = 1'b0;
        cyc(4);
        spi_word(0, 8'h60, 4, 1'b0, b1);
        chk("midrst_cs_low_ignored_oe", 32'(oe[0]), 0);
        cs_high(0);
        chk("midrst_no_tvalid", 32'(m_tvalid[0]), 0);
        cs_low(0, 8'h99);
        expect_rx(0, 8'h99);
        spi_word(0, 8'h99, 8, 1'b0, b1);
        cs_high(0);
        chk("after_rst_miso_dummy", 32'(b1), 32'hFF);

        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            cyc(1);
            n++;
        end
        chk("scoreboard_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
